// File: rtl/alu_risc_pkg.sv
// Shared opcodes, FSM state encoding and default widths for the sequential RISC ALU.
// The MUL opcode and MUL state exist only when ALU_RISC_MUL_EN is defined.
package alu_risc_pkg;

  localparam int WORD_SIZE_DEF = 8;
  localparam int OP_SIZE_DEF   = 4;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_NOT = 4'b0100;
  localparam logic [3:0] OP_EQZ = 4'b1001;
  localparam logic [3:0] OP_OR  = 4'b1010;
  localparam logic [3:0] OP_XOR = 4'b1011;
  localparam logic [3:0] OP_SHL = 4'b1100;
  localparam logic [3:0] OP_SHR = 4'b1101;
`ifdef ALU_RISC_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1110;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;
`else
  typedef enum logic {
    ST_IDLE = 1'b0
  } state_t;
`endif

endpackage

// File: rtl/alu_risc_seq_if.sv
// Request/result bundle of alu_risc_seq; master drives the request, slave returns the result.
// Handshake: a request is taken on any rising edge where start=1 and busy=0; done pulses
// for one cycle when alu_out and the flags carry the new result.
interface alu_risc_seq_if #(
  parameter int WORD_SIZE = alu_risc_pkg::WORD_SIZE_DEF,
  parameter int OP_SIZE   = alu_risc_pkg::OP_SIZE_DEF
);
  logic                 start;
  logic [OP_SIZE-1:0]   sel;
  logic [WORD_SIZE-1:0] data_1;
  logic [WORD_SIZE-1:0] data_2;
  logic                 busy;
  logic                 done;
  logic [WORD_SIZE-1:0] alu_out;
  logic                 zero_flag;
  logic                 carry_flag;
  logic                 neg_flag;
  logic                 ovf_flag;

  modport master (
    output start, sel, data_1, data_2,
    input  busy, done, alu_out, zero_flag, carry_flag, neg_flag, ovf_flag
  );

  modport slave (
    input  start, sel, data_1, data_2,
    output busy, done, alu_out, zero_flag, carry_flag, neg_flag, ovf_flag
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle into a 2*WORD_SIZE accumulator.
// o_done/o_product are combinational during the final iteration so the caller registers them.
module alu_mul_seq
  import alu_risc_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic [WORD_SIZE-1:0]   i_a,
  input  logic [WORD_SIZE-1:0]   i_b,
  output logic                   o_done,
  output logic [2*WORD_SIZE-1:0] o_product
);
  localparam int CW = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;

  logic                   r_run;
  logic [CW-1:0]          r_cnt;
  logic [2*WORD_SIZE-1:0] r_acc;
  logic [2*WORD_SIZE-1:0] r_mcand;
  logic [WORD_SIZE-1:0]   r_mplier;
  logic [2*WORD_SIZE-1:0] w_acc_next;

  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign o_done     = r_run && (r_cnt == CW'(WORD_SIZE - 1));
  assign o_product  = w_acc_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_run    <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (i_start) begin
      r_run    <= 1'b1;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= {{WORD_SIZE{1'b0}}, i_a};
      r_mplier <= i_b;
    end else if (r_run) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
      if (o_done) r_run <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_risc_seq.sv
// Sequential RISC ALU: single-cycle ops registered one cycle after start; the optional
// iterative MUL (macro ALU_RISC_MUL_EN) holds busy for WORD_SIZE cycles.
module alu_risc_seq
  import alu_risc_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int OP_SIZE   = OP_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [OP_SIZE-1:0]   sel,
  input  logic [WORD_SIZE-1:0] data_1,
  input  logic [WORD_SIZE-1:0] data_2,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_SIZE-1:0] alu_out,
  output logic                 zero_flag,
  output logic                 carry_flag,
  output logic                 neg_flag,
  output logic                 ovf_flag,
  output state_t               dbg_state
);
  localparam int MSB = WORD_SIZE - 1;

  state_t               r_state, w_next_state;
  logic                 w_accept_alu;
  logic [WORD_SIZE-1:0] w_res;
  logic [WORD_SIZE:0]   w_wide;
  logic                 w_carry, w_ovf;
  logic                 r_done;
  logic [WORD_SIZE-1:0] r_out;
  logic                 r_zero, r_carry, r_neg, r_ovf;

`ifdef ALU_RISC_MUL_EN
  logic                   w_mul_start;
  logic                   w_mul_done;
  logic [2*WORD_SIZE-1:0] w_prod;

  alu_mul_seq #(.WORD_SIZE(WORD_SIZE)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_mul_start),
    .i_a       (data_1),
    .i_b       (data_2),
    .o_done    (w_mul_done),
    .o_product (w_prod)
  );
`endif

  always_comb begin
    w_res   = '0;
    w_wide  = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (sel)
      OP_SIZE'(OP_ADD): begin
        w_wide  = {1'b0, data_1} + {1'b0, data_2};
        w_res   = w_wide[MSB:0];
        w_carry = w_wide[WORD_SIZE];
        w_ovf   = (data_1[MSB] == data_2[MSB]) && (w_res[MSB] != data_1[MSB]);
      end
      OP_SIZE'(OP_SUB), OP_SIZE'(OP_EQZ): begin
        // Borrow appears as the top bit of the extended difference.
        w_wide  = {1'b0, data_2} - {1'b0, data_1};
        w_res   = w_wide[MSB:0];
        w_carry = w_wide[WORD_SIZE];
        w_ovf   = (data_1[MSB] != data_2[MSB]) && (w_res[MSB] != data_2[MSB]);
      end
      OP_SIZE'(OP_AND): w_res = data_1 & data_2;
      OP_SIZE'(OP_NOT): w_res = ~data_2;
      OP_SIZE'(OP_OR):  w_res = data_1 | data_2;
      OP_SIZE'(OP_XOR): w_res = data_1 ^ data_2;
      OP_SIZE'(OP_SHL): begin
        w_res   = {data_2[MSB-1:0], 1'b0};
        w_carry = data_2[MSB];
      end
      OP_SIZE'(OP_SHR): begin
        w_res   = {1'b0, data_2[MSB:1]};
        w_carry = data_2[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    w_accept_alu = 1'b0;
`ifdef ALU_RISC_MUL_EN
    w_mul_start  = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (start) begin
`ifdef ALU_RISC_MUL_EN
          if (sel == OP_SIZE'(OP_MUL)) begin
            w_mul_start  = 1'b1;
            w_next_state = ST_MUL;
          end else
`endif
            w_accept_alu = 1'b1;
        end
      end
`ifdef ALU_RISC_MUL_EN
      ST_MUL: if (w_mul_done) w_next_state = ST_IDLE;
`endif
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
      r_out   <= '0;
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
      r_neg   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= 1'b0;
      if (w_accept_alu) begin
        r_out   <= w_res;
        r_zero  <= (w_res == '0);
        r_carry <= w_carry;
        r_neg   <= w_res[MSB];
        r_ovf   <= w_ovf;
        r_done  <= 1'b1;
      end
`ifdef ALU_RISC_MUL_EN
      else if (w_mul_done) begin
        r_out   <= w_prod[MSB:0];
        r_zero  <= (w_prod[MSB:0] == '0);
        r_carry <= |w_prod[2*WORD_SIZE-1:WORD_SIZE];
        r_neg   <= w_prod[MSB];
        r_ovf   <= 1'b0;
        r_done  <= 1'b1;
      end
`endif
    end
  end

  assign busy       = (r_state != ST_IDLE);
  assign done       = r_done;
  assign alu_out    = r_out;
  assign zero_flag  = r_zero;
  assign carry_flag = r_carry;
  assign neg_flag   = r_neg;
  assign ovf_flag   = r_ovf;
  assign dbg_state  = r_state;
endmodule

// File: tb/tb_alu_risc_seq.sv
// Bench for alu_risc_seq (WORD_SIZE=8): arithmetic reference model plus directed literal vectors.
// MUL vectors run when ALU_RISC_MUL_EN is defined; otherwise 1110 is checked as undefined.
module tb_alu_risc_seq;
  import alu_risc_pkg::*;

  localparam int W   = 8;
  localparam int OPW = 4;
`ifdef ALU_RISC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] out;
    logic       z, c, n, v;
  } res_t;

  logic   clk = 1'b0;
  logic   rst;
  state_t dbg_state;
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  bit     m_valid = 1'b0;
  bit     saw_busy = 1'b0;
  int     busy_lo = -1;
  int     busy_hi = -2;

  logic [W-1:0] exp_q[$];
  logic [3:0]   expf_q[$];
  int           due_q[$];
  logic [W-1:0] hold_out;
  logic [3:0]   hold_f;

  alu_risc_seq_if #(.WORD_SIZE(W), .OP_SIZE(OPW)) bus_if ();

  alu_risc_seq #(.WORD_SIZE(W), .OP_SIZE(OPW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (bus_if.start),
    .sel        (bus_if.sel),
    .data_1     (bus_if.data_1),
    .data_2     (bus_if.data_2),
    .busy       (bus_if.busy),
    .done       (bus_if.done),
    .alu_out    (bus_if.alu_out),
    .zero_flag  (bus_if.zero_flag),
    .carry_flag (bus_if.carry_flag),
    .neg_flag   (bus_if.neg_flag),
    .ovf_flag   (bus_if.ovf_flag),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "time limit");
  end

  // ---------------- reference model ----------------
  function automatic res_t model(input int op, input int a, input int b);
    res_t r;
    int   s, sa, sb, ss;
    r  = '0;
    s  = 0;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    case (op)
      1: begin
        s = a + b; r.c = (s > 255);
        ss = sa + sb; r.v = (ss > 127) || (ss < -128);
      end
      2, 9: begin
        s = b - a; r.c = (b < a);
        ss = sb - sa; r.v = (ss > 127) || (ss < -128);
      end
      3:  s = a & b;
      4:  s = 255 - b;
      10: s = a | b;
      11: s = a ^ b;
      12: begin s = b * 2; r.c = (s > 255); end
      13: begin s = b / 2; r.c = (b % 2) == 1; end
      14: if (MUL_EN) begin s = a * b; r.c = (s > 255); end
      default: s = 0;
    endcase
    r.out = 8'(s & 255);
    r.z   = (r.out == 8'h00);
    r.n   = (r.out >= 8'h80);
    return r;
  endfunction

  always @(posedge clk) begin : model_p
    int   n;
    res_t r;
    n = cyc;
    if (rst) begin
      exp_q.delete(); expf_q.delete(); due_q.delete();
      busy_lo = -1; busy_hi = -2;
      hold_out = '0; hold_f = '0;
      m_valid = 1'b1;
    end else if (m_valid && bus_if.start && !(n >= busy_lo && n <= busy_hi)) begin
      r = model(int'(bus_if.sel), int'(bus_if.data_1), int'(bus_if.data_2));
      exp_q.push_back(r.out);
      expf_q.push_back({r.z, r.c, r.n, r.v});
      if (MUL_EN && bus_if.sel == 4'hE) begin
        busy_lo = n + 1; busy_hi = n + W;
        due_q.push_back(n + W + 1);
      end else begin
        due_q.push_back(n + 1);
      end
    end
    cyc = n + 1;
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic int flags();
    return int'({bus_if.zero_flag, bus_if.carry_flag, bus_if.neg_flag, bus_if.ovf_flag});
  endfunction

  always @(negedge clk) begin : compare_p
    bit ed;
    if (m_valid) begin
      if (bus_if.busy === 1'b1) saw_busy = 1'b1;
      ed = (due_q.size() > 0) && (due_q[0] == cyc);
      check("model_done", int'(bus_if.done), int'(ed));
      check("model_busy", int'(bus_if.busy), int'(cyc >= busy_lo && cyc <= busy_hi));
      if (ed) begin
        hold_out = exp_q.pop_front();
        hold_f   = expf_q.pop_front();
        void'(due_q.pop_front());
      end
      check("model_alu_out", int'(bus_if.alu_out), int'(hold_out));
      check("model_flags", flags(), int'(hold_f));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int s, input int a, input int b);
    @(negedge clk);
    bus_if.start  = 1'b1;
    bus_if.sel    = 4'(s);
    bus_if.data_1 = 8'(a);
    bus_if.data_2 = 8'(b);
  endtask

  // flags argument ef is {zero, carry, neg, ovf}
  task automatic run_op(input string nm, input int s, input int a, input int b,
                        input int lat, input int eo, input int ef);
    int n0, w;
    drive(s, a, b);
    n0 = cyc;
    @(negedge clk);
    bus_if.start = 1'b0;
    w = 0;
    while (bus_if.done !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (bus_if.done !== 1'b1) begin
      check({nm, "_timeout"}, 0, 1);
    end else begin
      check({nm, "_latency"}, cyc - n0, lat);
      check({nm, "_out"}, int'(bus_if.alu_out), eo);
      check({nm, "_flags"}, flags(), ef);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    bus_if.start = 1'b0; bus_if.sel = '0; bus_if.data_1 = '0; bus_if.data_2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_out", int'(bus_if.alu_out), 0);
    check("reset_flags", flags(), 0);
    check("reset_done", int'(bus_if.done), 0);
    check("reset_busy", int'(bus_if.busy), 0);

    check("model_pin_add", int'(model(1, 'hF0, 'h20)), int'({8'h10, 4'b0100}));
    check("model_pin_sub", int'(model(2, 'h01, 'h80)), int'({8'h7F, 4'b0001}));

    run_op("add_f0_20", 1, 'hF0, 'h20, 1, 'h10, 'b0100);
    @(negedge clk);
    check("add_done_one_cycle", int'(bus_if.done), 0);
    run_op("sub_eq",   2,  'h05, 'h05, 1, 'h00, 'b1000);
    run_op("eqz_eq",   9,  'h05, 'h05, 1, 'h00, 'b1000);
    run_op("sub_ovf",  2,  'h01, 'h80, 1, 'h7F, 'b0001);
    run_op("add_ovf",  1,  'h7F, 'h01, 1, 'h80, 'b0011);
    run_op("sub_brw",  2,  'h10, 'h05, 1, 'hF5, 'b0110);
    run_op("and",      3,  'h3C, 'hF0, 1, 'h30, 'b0000);
    run_op("not",      4,  'h00, 'h0F, 1, 'hF0, 'b0010);
    run_op("or",       10, 'h0F, 'h30, 1, 'h3F, 'b0000);
    run_op("xor",      11, 'hFF, 'h0F, 1, 'hF0, 'b0010);
    run_op("shl",      12, 'h00, 'h81, 1, 'h02, 'b0100);
    run_op("shr",      13, 'h00, 'h81, 1, 'h40, 'b0100);
    run_op("nop",      0,  'h12, 'h34, 1, 'h00, 'b1000);
    run_op("undef",    5,  'h12, 'h34, 1, 'h00, 'b1000);

    // back-to-back single-cycle ops
    drive(1, 'h01, 'h02);
    drive(1, 'h03, 'h04);
    check("b2b_done0", int'(bus_if.done), 1);
    check("b2b_out0", int'(bus_if.alu_out), 'h03);
    drive(11, 'hAA, 'h0F);
    check("b2b_done1", int'(bus_if.done), 1);
    check("b2b_out1", int'(bus_if.alu_out), 'h07);
    @(negedge clk);
    bus_if.start = 1'b0;
    check("b2b_done2", int'(bus_if.done), 1);
    check("b2b_out2", int'(bus_if.alu_out), 'hA5);

`ifdef ALU_RISC_MUL_EN
    begin : mul_tests
      int n0, w;
      drive(14, 'h0C, 'h0B);
      n0 = cyc;
      @(negedge clk); bus_if.start = 1'b0;
      check("mul_busy_n1", int'(bus_if.busy), 1);
      @(negedge clk);
      drive(1, 'h01, 'h01);
      @(negedge clk); bus_if.start = 1'b0;
      w = 0;
      while (bus_if.done !== 1'b1 && w < 20) begin @(negedge clk); w++; end
      check("mul_latency", cyc - n0, 9);
      check("mul_out", int'(bus_if.alu_out), 'h84);
      check("mul_flags", flags(), 'b0010);
      @(negedge clk);
      check("mul_ignored_add", int'(bus_if.done), 0);
      run_op("mul_10_10", 14, 'h10, 'h10, 9, 'h00, 'b1100);
    end
`else
    run_op("mul_undef", 14, 'h0C, 'h0B, 1, 'h00, 'b1000);
`endif

    // reset in the middle of activity
    run_op("pre_rst_add", 1, 'h05, 'h06, 1, 'h0B, 'b0000);
`ifdef ALU_RISC_MUL_EN
    drive(14, 'h0C, 'h0B);
    @(negedge clk); bus_if.start = 1'b0;
    repeat (2) @(negedge clk);
`endif
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("rst_busy", int'(bus_if.busy), 0);
    check("rst_done", int'(bus_if.done), 0);
    check("rst_out", int'(bus_if.alu_out), 0);
    check("rst_flags", flags(), 0);
    repeat (10) @(negedge clk);
    run_op("post_rst_add", 1, 'h01, 'h01, 1, 'h02, 'b0000);

`ifndef ALU_RISC_MUL_EN
    check("busy_never_high", int'(saw_busy), 0);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
